// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues imem reads and buffers returned words for decode.
// Latency: request in cycle N -> out_valid_o in N+2. Backpressure: credit-gated requests; hold/full stop fetch.
// Optional FETCH_CTRL_MISALIGN_TRAP_EN: misaligned redirect targets raise sticky misalign_o and stop fetch.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              hold_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [INST_W-1:0] out_inst_o,
    input  logic              out_ready_i
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic              epoch, epoch_d;
    logic              inflight;
    logic              tag_epoch;
    logic [ADDR_W-1:0] tag_pc;

    logic [ADDR_W-1:0] mem_pc   [BUF_DEPTH];
    logic [INST_W-1:0] mem_inst [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_d, cnt_eff;
    logic [CNT_W:0]    occ;

    logic              pop, push, flush, credit, fetch_ok, bad_target, mis;
    logic [ADDR_W-1:0] target;

    assign target = redirect_pc_i & ~ADDR_W'(3);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic mis_q;
    assign bad_target = |redirect_pc_i[1:0];
    assign mis        = mis_q;
    assign misalign_o = mis_q;
`else
    assign bad_target = 1'b0;
    assign mis        = 1'b0;
`endif

    assign out_valid_o = (count != '0);
    assign out_pc_o    = mem_pc[rd_ptr];
    assign out_inst_o  = mem_inst[rd_ptr];

    // A slot freed by this cycle's pop is already available to a new request.
    assign pop      = out_ready_i && out_valid_o;
    assign cnt_eff  = count - CNT_W'(pop);
    assign occ      = {1'b0, cnt_eff} + (CNT_W+1)'(inflight);
    assign credit   = occ < (CNT_W+1)'(BUF_DEPTH);
    assign fetch_ok = credit && !hold_i && !mis;
    assign flush    = redirect_i && (state != ST_BOOT);
    assign push     = inflight && (tag_epoch == epoch) && !flush;
    assign epoch_d  = epoch ^ flush;
    assign count_d  = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc;
        state_d     = state;
        pc_d        = pc;
        if (state == ST_BOOT) begin
            state_d = ST_RUN;
            if (redirect_i) pc_d = target;
        end else if (redirect_i) begin
            if (bad_target || hold_i) begin
                state_d = ST_STALL;
                pc_d    = target;
            end else begin
                imem_req_o  = 1'b1;
                imem_addr_o = target;
                pc_d        = target + ADDR_W'(4);
                state_d     = ST_RUN;
            end
        end else begin
            if (state == ST_RUN && fetch_ok) begin
                imem_req_o = 1'b1;
                pc_d       = pc + ADDR_W'(4);
            end
            state_d = fetch_ok ? ST_RUN : ST_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            epoch     <= 1'b0;
            inflight  <= 1'b0;
            tag_epoch <= 1'b0;
            tag_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            epoch    <= epoch_d;
            inflight <= imem_req_o;
            if (imem_req_o) begin
                tag_pc    <= imem_addr_o;
                tag_epoch <= epoch_d;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]   <= tag_pc;
                    mem_inst[wr_ptr] <= imem_rdata_i;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_d;
            end
        end
    end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)        mis_q <= 1'b0;
        else if (flush) mis_q <= bad_target;
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based behavioural model of the fetch stream.
module tb_fetch_ctrl;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_i = 1'b0;
    logic [AW-1:0] redirect_pc_i = '0;
    logic          hold_i = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [IW-1:0] imem_rdata_i = '0;
    logic          out_valid_o;
    logic [AW-1:0] out_pc_o;
    logic [IW-1:0] out_inst_o;
    logic          out_ready_i = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(AW), .INST_W(IW), .RESET_PC('0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .hold_i(hold_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .out_valid_o(out_valid_o), .out_pc_o(out_pc_o),
        .out_inst_o(out_inst_o), .out_ready_i(out_ready_i)
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model state: buffered words, one outstanding fetch, next sequential PC.
    ent_t          fq[$];
    bit            m_init = 0, m_boot = 1, m_blocked = 0, m_mis = 0, m_inf = 0;
    logic [AW-1:0] m_pc = '0, m_inf_pc = '0;

    bit            prev_req = 0;
    logic [AW-1:0] prev_addr = '0;
    logic          o_req, o_valid, o_mis;
    logic [AW-1:0] o_addr, o_pc;
    logic [IW-1:0] o_inst;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic [AW-1:0] rpc,
                       input logic h, input logic rdy);
        bit            pop, can, bad, e_req, e_valid;
        int            occ;
        logic [AW-1:0] tgt, e_addr;
        @(negedge clk);
        rst = r; redirect_i = rd; redirect_pc_i = rpc; hold_i = h; out_ready_i = rdy;
        imem_rdata_i = prev_req ? mem_word(prev_addr) : IW'($urandom);
        #1;
        e_valid = fq.size() != 0;
        pop = rdy && e_valid;
        occ = fq.size() - int'(pop) + int'(m_inf);
        tgt = {rpc[AW-1:2], 2'b00};
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        bad = rpc[1:0] != 2'b00;
`else
        bad = 0;
`endif
        can = (occ < DEPTH) && !h && !m_mis;
        e_req = 0;
        e_addr = '0;
        if (!m_boot) begin
            if (rd) begin
                if (!bad && !h) begin e_req = 1; e_addr = tgt; end
            end else if (can && !m_blocked) begin
                e_req = 1; e_addr = m_pc;
            end
        end
        if (m_init) begin
            chk("req", AW'(imem_req_o), AW'(e_req));
            if (e_req) chk("addr", imem_addr_o, e_addr);
            chk("valid", AW'(out_valid_o), AW'(e_valid));
            if (e_valid) begin
                chk("out_pc", out_pc_o, fq[0].pc);
                chk("out_inst", AW'(out_inst_o), AW'(fq[0].inst));
            end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            chk("misalign", AW'(misalign_o), AW'(m_mis));
            o_mis = misalign_o;
`endif
        end
        o_req = imem_req_o; o_addr = imem_addr_o; o_valid = out_valid_o;
        o_pc = out_pc_o; o_inst = out_inst_o;
        prev_req = imem_req_o; prev_addr = imem_addr_o;
        // Advance the model to the state after this rising edge.
        if (r) begin
            fq.delete(); m_inf = 0; m_pc = '0; m_boot = 1; m_blocked = 0; m_mis = 0; m_init = 1;
        end else if (m_boot) begin
            if (m_inf) fq.push_back('{pc: m_inf_pc, inst: mem_word(m_inf_pc)});
            if (rd) m_pc = tgt;
            m_boot = 0; m_blocked = 0; m_inf = 0;
        end else begin
            if (rd) begin
                fq.delete();
                m_pc = e_req ? tgt + 4 : tgt;
                m_blocked = !e_req;
                m_mis = bad;
            end else begin
                if (pop) void'(fq.pop_front());
                if (m_inf) fq.push_back('{pc: m_inf_pc, inst: mem_word(m_inf_pc)});
                if (e_req) m_pc = m_pc + 4;
                m_blocked = !can;
            end
            m_inf = e_req;
            m_inf_pc = e_addr;
        end
    endtask

    initial begin
        cyc(1, 0, '0, 0, 0);
        cyc(1, 0, '0, 0, 0);
        // Reset release, streaming with ready held high.
        cyc(0, 0, '0, 0, 1);
        chk("boot_req", AW'(o_req), 0);
        chk("boot_valid", AW'(o_valid), 0);
        chk("boot_pc", o_pc, 0);
        chk("boot_inst", AW'(o_inst), 0);
        cyc(0, 0, '0, 0, 1); chk("c1_req", AW'(o_req), 1); chk("c1_addr", o_addr, 0);
        cyc(0, 0, '0, 0, 1); chk("c2_addr", o_addr, 4);
        cyc(0, 0, '0, 0, 1); chk("c3_valid", AW'(o_valid), 1); chk("c3_pc", o_pc, 0);
        chk("c3_inst", AW'(o_inst), AW'(mem_word(0)));
        cyc(0, 0, '0, 0, 1); chk("c4_pc", o_pc, 4);
        // Decode stalls: buffer fills with two words and fetch stops.
        for (int i = 0; i < 6; i++) cyc(0, 0, '0, 0, 0);
        chk("full_req", AW'(o_req), 0);
        chk("full_pc", o_pc, 8);
        cyc(0, 0, '0, 0, 1); chk("rel_pc0", o_pc, 8);
        cyc(0, 0, '0, 0, 1); chk("rel_pc1", o_pc, 12);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, '0, 0, 0);
        // Redirect flushes buffered and in-flight words.
        cyc(0, 1, 64'h1000, 0, 1);
        chk("redir_req", AW'(o_req), 1); chk("redir_addr", o_addr, 64'h1000);
        cyc(0, 0, '0, 0, 1); chk("redir_flush", AW'(o_valid), 0);
        cyc(0, 0, '0, 0, 1); chk("redir_valid", AW'(o_valid), 1); chk("redir_pc", o_pc, 64'h1000);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1);
        // Hold freezes requests while decode drains the buffer.
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 1);
        chk("hold_req", AW'(o_req), 0);
        chk("hold_drained", AW'(o_valid), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 1);
        // PC wraps at the top of the address space.
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1);
        cyc(0, 0, '0, 0, 1); chk("wrap_fc", o_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, '0, 0, 1); chk("wrap_req", AW'(o_req), 1); chk("wrap_addr", o_addr, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1);
        // Reset mid-stream.
        cyc(1, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 1);
        chk("mrst_req", AW'(o_req), 0); chk("mrst_valid", AW'(o_valid), 0);
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 1);
        cyc(0, 1, 64'h1002, 0, 1); chk("mis_noreq", AW'(o_req), 0);
        cyc(0, 0, '0, 0, 1); chk("mis_set", AW'(o_mis), 1); chk("mis_empty", AW'(o_valid), 0);
        cyc(0, 0, '0, 0, 1); chk("mis_stay", AW'(o_req), 0);
        cyc(0, 1, 64'h2000, 0, 1); chk("mis_clr_addr", o_addr, 64'h2000);
        cyc(0, 0, '0, 0, 1); chk("mis_clr", AW'(o_mis), 0);
`endif
        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic          r, rd, h, rdy;
            logic [AW-1:0] rpc;
            r   = ($urandom_range(0, 399) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            h   = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: rpc = {32'h0, $urandom_range(0, 255) * 32'd4};
                1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | AW'($urandom_range(0, 15));
                2: rpc = {$urandom, $urandom};
                default: rpc = {32'h0, 32'h0001_0000 | ($urandom & 32'hFFF)};
            endcase
            cyc(r, rd, rpc, h, rdy);
        end
        cyc(0, 0, '0, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
